bitwise_unit_arbiter: RTL

//  Shares one 32-bit combinational bitwise logic unit (AND/OR/XOR/NOR) among
//  NUM_REQ requesters. Round-robin arbitration, valid/ready handshake per

---
 rtl/bitwise_pkg.sv | 10 +
 rtl/bitwise_logic_unit.sv | 15 +
 rtl/bitwise_unit_arbiter.sv | 94 +++++++++
 3 files changed

// File: rtl/bitwise_pkg.sv
// bitwise_pkg: op codes and FSM state encodings shared by the bitwise arbiter slice.
package bitwise_pkg;
    localparam logic [1:0] OP_AND  = 2'd0;
    localparam logic [1:0] OP_OR   = 2'd1;
    localparam logic [1:0] OP_XOR  = 2'd2;
    localparam logic [1:0] OP_NOR  = 2'd3;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
endpackage

// File: rtl/bitwise_logic_unit.sv
// bitwise_logic_unit: combinational AND/OR/XOR/NOR over full operand width.
module bitwise_logic_unit
    import bitwise_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] z
);
    always_comb z = op == OP_AND ? x & y :
                    op == OP_OR  ? x | y :
                    op == OP_XOR ? x ^ y : ~(x | y);
endmodule

// File: rtl/bitwise_unit_arbiter.sv
// bitwise_unit_arbiter: round-robin sharing of one bitwise logic unit among NUM_REQ requesters,
// with a registered, ID-tagged result held until the consumer takes it.
module bitwise_unit_arbiter
    import bitwise_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [2*NUM_REQ-1:0]     req_op,
    input  logic [WIDTH*NUM_REQ-1:0] req_x,
    input  logic [WIDTH*NUM_REQ-1:0] req_y,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [WIDTH-1:0]         rsp_z,
    output logic                     busy
);
    logic [1:0]       state;
    logic [ID_W-1:0]  rr_ptr, gnt, id_r;
    logic [ID_W:0]    cand;
    logic             found;
    logic [1:0]       op_r;
    logic [WIDTH-1:0] x_r, y_r, z;

    // First valid index at or above rr_ptr, wrapping past NUM_REQ-1.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (ID_W+1)'(k);
            cand = cand >= (ID_W+1)'(NUM_REQ) ? cand - (ID_W+1)'(NUM_REQ) : cand;
            if (!found && req_valid[cand[ID_W-1:0]]) begin
                found = 1'b1;
                gnt   = cand[ID_W-1:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (rst_n && state == ST_IDLE && found) req_ready[gnt] = 1'b1;
    end

    assign busy = state != ST_IDLE;

    bitwise_logic_unit #(.WIDTH(WIDTH)) u_unit (
        .x  (x_r),
        .y  (y_r),
        .op (op_r),
        .z  (z)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            id_r      <= '0;
            op_r      <= '0;
            x_r       <= '0;
            y_r       <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_z     <= '0;
        end else begin
            case (state)
                ST_IDLE: if (found) begin
                    op_r   <= req_op[2*gnt +: 2];
                    x_r    <= req_x[WIDTH*gnt +: WIDTH];
                    y_r    <= req_y[WIDTH*gnt +: WIDTH];
                    id_r   <= gnt;
                    rr_ptr <= gnt == ID_W'(NUM_REQ-1) ? '0 : gnt + 1'b1;
                    state  <= ST_EXEC;
                end
                ST_EXEC: begin
                    rsp_z     <= z;
                    rsp_id    <= id_r;
                    rsp_valid <= 1'b1;
                    state     <= ST_RESP;
                end
                ST_RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
